// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the switching-pattern ROM sequencer.
package pwm_seq_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FAULT = 2'd3;

  // ROM is read only while the sequencer is walking addresses.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/phase_accum.sv
// Phase accumulator: holds the step/period settings for the current period and
// computes the next ROM address modulo (last+1), flagging each wrap.
module phase_accum #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              wrap
);

  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W:0]   period;
  logic [ADDR_W:0]   step_eff;
  logic [ADDR_W:0]   sum;

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    step_d = step_q;
    last_d = last_q;

    // One extra bit so last = all-ones still yields a correct period of 2**ADDR_W.
    period = {1'b0, last_q} + {{ADDR_W{1'b0}}, 1'b1};

    if (step_q == '0) begin
      step_eff = {{ADDR_W{1'b0}}, 1'b1};
    end else if ({1'b0, step_q} > period) begin
      step_eff = period;
    end else begin
      step_eff = {1'b0, step_q};
    end

    sum  = {1'b0, addr} + step_eff;
    wrap = sum > {1'b0, last_q};
    // The wrapped result always fits in ADDR_W bits, so modular subtraction is exact.
    next_addr = wrap ? (sum[ADDR_W-1:0] - period[ADDR_W-1:0]) : sum[ADDR_W-1:0];

    // New settings only take hold at a period boundary, keeping frequency changes glitch-free.
    if (load || (advance && wrap)) begin
      step_d = step;
      last_d = last_addr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (!rst_n) begin
      step_q <= '0;
      last_q <= '0;
    end else begin
      step_q <= step_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rom_pwm_sequencer.sv
// Address sequencer for the 3x4-bit switching-pattern ROM: run/drain/fault control,
// ROM enable, and re-timing of ROM words onto the gate outputs.
module rom_pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              fault,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_out1,
  input  logic [DATA_W-1:0] rom_out2,
  input  logic [DATA_W-1:0] rom_out3,
  output logic [DATA_W-1:0] gate1,
  output logic [DATA_W-1:0] gate2,
  output logic [DATA_W-1:0] gate3,
  output logic              gate_valid,
  output logic              period_tick,
  output logic              busy,
  output logic              fault_lat
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              tick_q, tick_d;
  logic [ROM_LAT:0]  vld_q, vld_d;
  logic [DATA_W-1:0] gate1_q, gate1_d;
  logic [DATA_W-1:0] gate2_q, gate2_d;
  logic [DATA_W-1:0] gate3_q, gate3_d;

  logic              load;
  logic              advance;
  logic [ADDR_W-1:0] next_addr;
  logic              wrap;

  phase_accum #(
    .ADDR_W(ADDR_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .step      (step),
    .last_addr (last_addr),
    .addr      (rom_addr_q),
    .next_addr (next_addr),
    .wrap      (wrap)
  );

  assign rom_en = is_active(state_q);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    load       = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rom_addr_d = '0;
        if (start && !stop) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        advance    = 1'b1;
        rom_addr_d = next_addr;
        if (stop) begin
          state_d = wrap ? ST_IDLE : ST_DRAIN;
          if (wrap) rom_addr_d = '0;
        end
      end
      ST_DRAIN: begin
        advance    = 1'b1;
        rom_addr_d = next_addr;
        if (wrap) begin
          state_d    = ST_IDLE;
          rom_addr_d = '0;
        end else if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        rom_addr_d = '0;
        if (!fault && start) state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        rom_addr_d = '0;
      end
    endcase

    // Fault overrides everything, including an in-flight wrap.
    if (fault) begin
      state_d    = ST_FAULT;
      rom_addr_d = '0;
      load       = 1'b0;
      advance    = 1'b0;
    end

    tick_d = advance && wrap;

    // Entering FAULT discards whatever ROM words are still in the pipe.
    vld_d = (state_d == ST_FAULT) ? '0 : {vld_q[ROM_LAT-1:0], rom_en};

    gate1_d = vld_d[ROM_LAT] ? rom_out1 : '0;
    gate2_d = vld_d[ROM_LAT] ? rom_out2 : '0;
    gate3_d = vld_d[ROM_LAT] ? rom_out3 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      tick_q     <= 1'b0;
      vld_q      <= '0;
      gate1_q    <= '0;
      gate2_q    <= '0;
      gate3_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tick_q     <= tick_d;
      vld_q      <= vld_d;
      gate1_q    <= gate1_d;
      gate2_q    <= gate2_d;
      gate3_q    <= gate3_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign period_tick = tick_q;
  assign gate_valid  = vld_q[ROM_LAT];
  assign gate1       = gate1_q;
  assign gate2       = gate2_q;
  assign gate3       = gate3_q;
  assign busy        = (state_q != ST_IDLE);
  assign fault_lat   = (state_q == ST_FAULT);

endmodule
